trap_eval_pipe: RTL and testbench
=================================

TRAP_EVAL_PIPE -- requirements
Module: trap_eval_pipe

Interface
REQ-001 SHALL have parameter WAYS, default 2: number of issue ways evaluated per cycle, legal range 1..4.
REQ-002 SHALL have parameter DATA_W, default 32: operand and immediate width.
REQ-003 SHALL have parameter CNT_W, default 16: width of the trap counter.
REQ-004 SHALL have parameter EXC_TR, default 5'h0D: trap exception code.
REQ-005 SHALL have parameter EXC_NONE, default 5'h00: "no exception" code.
REQ-006 SHALL have ports as follows (one per line: name direction width meaning):
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  WAYS  per-way instruction valid.
- in_exc_code  in  5*WAYS  exception already raised upstream, EXC_NONE if none.
- in_is_trap  in  WAYS  way holds a conditional-trap instruction.
- in_trap_op  in  3*WAYS  compare op: 0 EQ, 1 NE, 2 GE signed, 3 GEU, 4 LT signed, 5 LTU, 6/7 never.
- in_src_b_imm  in  WAYS  1: compare against immediate; 0: against rt.
- in_rs, in_rt, in_imm  in  DATA_W*WAYS each  operand A, operand B register, sign-extended immediate.
- stall  in  1  hold output stage.
- flush  in  1  discard output stage contents.
- out_valid  out  1  registered result valid.
- out_exc_code  out  5  winning exception code.
- out_way  out  WAYS  one-hot winning way, all-zero if none.
- out_trap_hit  out  1  winning exception is a taken trap.
- trap_count  out  CNT_W  saturating count of taken traps.

Function
REQ-007 SHALL evaluate per way: cond = op(in_rs, B), where B = in_imm if in_src_b_imm else in_rt; signed ops compare two's complement over DATA_W; unsigned ops compare zero-extended.
REQ-008 SHALL treat ops 6 and 7 as cond = 0.
REQ-009 SHALL define per-way exception: in_valid & (in_exc_code != EXC_NONE ? in_exc_code : (in_is_trap & cond ? EXC_TR : EXC_NONE)); an upstream code overrides trap evaluation of the same way.
REQ-010 SHALL select the lowest-index way with exception != EXC_NONE as winner; a not-taken trap in a lower way SHALL NOT mask an exception in a higher way.
REQ-011 SHALL register the result; latency exactly 1 cycle from inputs to out_* when stall = 0.
REQ-012 SHALL, when stall = 1 and flush = 0, hold all out_* and trap_count unchanged and ignore inputs.
REQ-013 SHALL, when flush = 1, set out_valid = 0, out_exc_code = EXC_NONE, out_way = 0, out_trap_hit = 0 next cycle regardless of stall; flush wins over stall.
REQ-014 SHALL set out_valid = 1 on capture if any in_valid bit is 1, else 0.
REQ-015 SHALL, when no way has an exception, output out_exc_code = EXC_NONE, out_way = 0, out_trap_hit = 0.
REQ-016 SHALL increment trap_count by 1 on each capture (stall = 0, flush = 0) where winner's code is EXC_TR from trap evaluation; upstream EXC_TR codes SHALL NOT count.
REQ-017 SHALL saturate trap_count at all-ones; no wrap.
REQ-018 SHALL contain no combinational path from inputs to outputs.

Reset
REQ-019 SHALL, on rst = 1 at a rising edge, set out_valid = 0, out_exc_code = EXC_NONE, out_way = 0, out_trap_hit = 0, trap_count = 0.
REQ-020 SHALL give rst priority over flush, stall, and capture; reset mid-stall clears held state.

Verification
REQ-021 SHALL cover: way0 TEQ rs=5 rt=5, way1 valid no exception -> next cycle out_exc_code=0x0D, out_way=01, out_trap_hit=1, trap_count=1.
REQ-022 SHALL cover: way0 TNE rs=rt=7 (not taken), way1 in_exc_code=0x04 -> out_exc_code=0x04, out_way=10, out_trap_hit=0, trap_count unchanged.
REQ-023 SHALL cover: signed/unsigned boundary, rs=0x80000000, imm=0x00000001, way0 LT -> taken; same with LTU -> not taken, out_exc_code=0.
REQ-024 SHALL cover: capture trap, then stall=1 for 3 cycles with changing inputs -> outputs and trap_count held; stall+flush same cycle -> out_valid=0 next cycle.
REQ-025 SHALL cover: CNT_W=4, 17 consecutive taken traps -> trap_count saturates at 15.
REQ-026 SHALL cover: rst asserted during stall with valid trap held -> all outputs zero next cycle, trap_count=0.

Source files
------------

// File: rtl/trap_eval_pipe.sv
// -----------------------------------------------------------------------------
// trap_eval_pipe
//
// Evaluates conditional-trap instructions for WAYS issue ways in one cycle,
// merges them with exceptions already raised upstream, picks the lowest-index
// way that carries an exception, and registers the result (1-cycle latency).
// A saturating counter tracks how many captured winners were taken traps.
//
// Ports
//   clk            sole clock, all state on rising edge
//   rst            synchronous, active-high reset
//   in_valid       [WAYS]        per-way instruction valid
//   in_exc_code    [5*WAYS]      upstream exception code, EXC_NONE if none
//   in_is_trap     [WAYS]        way holds a conditional-trap instruction
//   in_trap_op     [3*WAYS]      0 EQ, 1 NE, 2 GE, 3 GEU, 4 LT, 5 LTU, 6/7 never
//   in_src_b_imm   [WAYS]        1: compare against in_imm, 0: against in_rt
//   in_rs          [DATA_W*WAYS] operand A
//   in_rt          [DATA_W*WAYS] operand B register
//   in_imm         [DATA_W*WAYS] sign-extended immediate
//   stall          hold the output stage, ignore inputs
//   flush          empty the output stage (wins over stall)
//   out_valid      registered result valid
//   out_exc_code   winning exception code
//   out_way        one-hot winning way, all-zero if none
//   out_trap_hit   winner is a trap taken by this stage's evaluation
//   trap_count     saturating count of taken traps
// -----------------------------------------------------------------------------
module trap_eval_pipe #(
  parameter int             WAYS     = 2,
  parameter int             DATA_W   = 32,
  parameter int             CNT_W    = 16,
  parameter logic [4:0]     EXC_TR   = 5'h0D,
  parameter logic [4:0]     EXC_NONE = 5'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WAYS-1:0]        in_valid,
  input  logic [5*WAYS-1:0]      in_exc_code,
  input  logic [WAYS-1:0]        in_is_trap,
  input  logic [3*WAYS-1:0]      in_trap_op,
  input  logic [WAYS-1:0]        in_src_b_imm,
  input  logic [DATA_W*WAYS-1:0] in_rs,
  input  logic [DATA_W*WAYS-1:0] in_rt,
  input  logic [DATA_W*WAYS-1:0] in_imm,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [4:0]             out_exc_code,
  output logic [WAYS-1:0]        out_way,
  output logic                   out_trap_hit,
  output logic [CNT_W-1:0]       trap_count
);

  localparam logic [2:0] OP_EQ  = 3'd0;
  localparam logic [2:0] OP_NE  = 3'd1;
  localparam logic [2:0] OP_GE  = 3'd2;
  localparam logic [2:0] OP_GEU = 3'd3;
  localparam logic [2:0] OP_LT  = 3'd4;
  localparam logic [2:0] OP_LTU = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic eval_cond(input logic [2:0]        op,
                                     input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
    case (op)
      OP_EQ:   return a == b;
      OP_NE:   return a != b;
      OP_GE:   return $signed(a) >= $signed(b);
      OP_GEU:  return a >= b;
      OP_LT:   return $signed(a) <  $signed(b);
      OP_LTU:  return a <  b;
      default: return 1'b0;   // ops 6/7 never trap
    endcase
  endfunction

  // Per-way evaluation results.
  logic [4:0]      way_exc  [WAYS];
  logic [WAYS-1:0] way_taken;

  // Winner of the priority select.
  logic            win_found;
  logic [4:0]      win_code;
  logic [WAYS-1:0] win_way;
  logic            win_trap;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    way_taken = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_exc[w] = EXC_NONE;
      if (in_valid[w]) begin
        if (in_exc_code[5*w +: 5] != EXC_NONE) begin
          // Upstream exception overrides this way's trap evaluation.
          way_exc[w] = in_exc_code[5*w +: 5];
        end else if (in_is_trap[w] &&
                     eval_cond(in_trap_op[3*w +: 3],
                               in_rs[DATA_W*w +: DATA_W],
                               in_src_b_imm[w] ? in_imm[DATA_W*w +: DATA_W]
                                               : in_rt[DATA_W*w +: DATA_W])) begin
          way_exc[w]   = EXC_TR;
          way_taken[w] = 1'b1;
        end
      end
    end

    // Lowest-index way with a real exception wins; ways whose trap was not
    // taken carry EXC_NONE and therefore never mask a higher way.
    win_found = 1'b0;
    win_code  = EXC_NONE;
    win_way   = '0;
    win_trap  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!win_found && way_exc[w] != EXC_NONE) begin
        win_found  = 1'b1;
        win_code   = way_exc[w];
        win_way[w] = 1'b1;
        win_trap   = way_taken[w];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_exc_code <= EXC_NONE;
      out_way      <= '0;
      out_trap_hit <= 1'b0;
      trap_count   <= '0;
    end else if (flush) begin
      // Flush empties the stage but leaves the trap statistics alone.
      out_valid    <= 1'b0;
      out_exc_code <= EXC_NONE;
      out_way      <= '0;
      out_trap_hit <= 1'b0;
    end else if (!stall) begin
      out_valid    <= |in_valid;
      out_exc_code <= win_code;
      out_way      <= win_way;
      out_trap_hit <= win_trap;
      if (win_trap && trap_count != CNT_MAX) begin
        trap_count <= trap_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_trap_eval_pipe.sv
// -----------------------------------------------------------------------------
// tb_trap_eval_pipe
//
// Drives two trap_eval_pipe instances (default CNT_W and CNT_W=4) with the
// same stimulus: directed scenarios with literal expectations, then randomized
// traffic. A behavioural model computes the expected registered outputs from
// the functional rules and is compared against the DUTs every cycle.
// -----------------------------------------------------------------------------
module tb_trap_eval_pipe;

  localparam int         WAYS     = 2;
  localparam int         DATA_W   = 32;
  localparam logic [4:0] EXC_TR   = 5'h0D;
  localparam logic [4:0] EXC_NONE = 5'h00;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [WAYS-1:0]        in_valid;
  logic [5*WAYS-1:0]      in_exc_code;
  logic [WAYS-1:0]        in_is_trap;
  logic [3*WAYS-1:0]      in_trap_op;
  logic [WAYS-1:0]        in_src_b_imm;
  logic [DATA_W*WAYS-1:0] in_rs;
  logic [DATA_W*WAYS-1:0] in_rt;
  logic [DATA_W*WAYS-1:0] in_imm;
  logic                   stall;
  logic                   flush;

  logic                   out_valid;
  logic [4:0]             out_exc_code;
  logic [WAYS-1:0]        out_way;
  logic                   out_trap_hit;
  logic [15:0]            trap_count;

  logic                   s_out_valid;
  logic [4:0]             s_out_exc_code;
  logic [WAYS-1:0]        s_out_way;
  logic                   s_out_trap_hit;
  logic [3:0]             s_trap_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model state.
  logic       m_valid;
  logic [4:0] m_code;
  logic [1:0] m_way;
  logic       m_hit;
  int         m_cnt16;
  int         m_cnt4;

  always #5 clk = ~clk;

  trap_eval_pipe #(
    .WAYS(WAYS), .DATA_W(DATA_W), .CNT_W(16), .EXC_TR(EXC_TR), .EXC_NONE(EXC_NONE)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_exc_code(in_exc_code),
    .in_is_trap(in_is_trap), .in_trap_op(in_trap_op), .in_src_b_imm(in_src_b_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_exc_code(out_exc_code), .out_way(out_way),
    .out_trap_hit(out_trap_hit), .trap_count(trap_count)
  );

  trap_eval_pipe #(
    .WAYS(WAYS), .DATA_W(DATA_W), .CNT_W(4), .EXC_TR(EXC_TR), .EXC_NONE(EXC_NONE)
  ) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_exc_code(in_exc_code),
    .in_is_trap(in_is_trap), .in_trap_op(in_trap_op), .in_src_b_imm(in_src_b_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .stall(stall), .flush(flush),
    .out_valid(s_out_valid), .out_exc_code(s_out_exc_code), .out_way(s_out_way),
    .out_trap_hit(s_out_trap_hit), .trap_count(s_trap_count)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Behavioural reference: what the registered stage must hold after this edge.
  task automatic model_update();
    logic       found;
    logic [4:0] code;
    logic [1:0] way;
    logic       hit;
    logic [4:0] ec;
    logic       taken;
    logic [31:0] a, b;
    longint     sa, sb, ua, ub;
    if (rst) begin
      m_valid = 0; m_code = EXC_NONE; m_way = 0; m_hit = 0; m_cnt16 = 0; m_cnt4 = 0;
    end else if (flush) begin
      m_valid = 0; m_code = EXC_NONE; m_way = 0; m_hit = 0;
    end else if (!stall) begin
      found = 0; code = EXC_NONE; way = 0; hit = 0;
      for (int w = 0; w < WAYS; w++) begin
        if (!in_valid[w]) continue;
        ec    = in_exc_code[5*w +: 5];
        taken = 0;
        if (ec == EXC_NONE && in_is_trap[w]) begin
          a  = in_rs[32*w +: 32];
          b  = in_src_b_imm[w] ? in_imm[32*w +: 32] : in_rt[32*w +: 32];
          sa = longint'($signed(a)); sb = longint'($signed(b));
          ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
          case (in_trap_op[3*w +: 3])
            3'd0: taken = (ua == ub);
            3'd1: taken = (ua != ub);
            3'd2: taken = (sa >= sb);
            3'd3: taken = (ua >= ub);
            3'd4: taken = (sa <  sb);
            3'd5: taken = (ua <  ub);
            default: taken = 0;
          endcase
          if (taken) ec = EXC_TR;
        end
        if (ec != EXC_NONE && !found) begin
          found = 1; code = ec; way = 2'(1 << w); hit = taken;
        end
      end
      m_valid = |in_valid;
      m_code  = code;
      m_way   = way;
      m_hit   = hit;
      if (hit) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4  < 15)    m_cnt4++;
      end
    end
  endtask

  task automatic compare_all();
    check("out_valid",    32'(out_valid),    32'(m_valid));
    check("out_exc_code", 32'(out_exc_code), 32'(m_code));
    check("out_way",      32'(out_way),      32'(m_way));
    check("out_trap_hit", 32'(out_trap_hit), 32'(m_hit));
    check("trap_count",   32'(trap_count),   32'(m_cnt16));
    check("trap_count_sat", 32'(s_trap_count), 32'(m_cnt4));
  endtask

  // One clock: inputs are already driven; model and DUT see the same edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    rst = 0; stall = 0; flush = 0;
    in_valid = '0; in_exc_code = '0; in_is_trap = '0; in_trap_op = '0;
    in_src_b_imm = '0; in_rs = '0; in_rt = '0; in_imm = '0;
  endtask

  task automatic set_way(input int w, input logic v, input logic [4:0] exc,
                         input logic trap, input logic [2:0] op, input logic bimm,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm);
    in_valid[w]          = v;
    in_exc_code[5*w +: 5] = exc;
    in_is_trap[w]        = trap;
    in_trap_op[3*w +: 3] = op;
    in_src_b_imm[w]      = bimm;
    in_rs[32*w +: 32]    = rs;
    in_rt[32*w +: 32]    = rt;
    in_imm[32*w +: 32]   = imm;
  endtask

  task automatic randomize_ways();
    logic [31:0] r;
    for (int w = 0; w < WAYS; w++) begin
      r = $urandom;
      set_way(w, r[0],
              (r[3:1] == 0) ? 5'($urandom_range(1, 31)) :
              (r[3:1] == 1) ? EXC_TR : EXC_NONE,
              r[4], 3'($urandom_range(0, 7)), r[5],
              r[6] ? $urandom : 32'($urandom_range(0, 3)) - 32'd1,
              r[7] ? $urandom : 32'($urandom_range(0, 3)) - 32'd1,
              r[8] ? $urandom : 32'($urandom_range(0, 3)) - 32'd1);
    end
  endtask

  initial begin
    clear_inputs();
    m_valid = 0; m_code = 0; m_way = 0; m_hit = 0; m_cnt16 = 0; m_cnt4 = 0;

    // Reset state.
    rst = 1; step();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_count", 32'(trap_count), 32'd0);
    rst = 0;

    // way0 TEQ 5==5 taken, way1 valid without exception.
    set_way(0, 1, EXC_NONE, 1, 3'd0, 0, 32'd5, 32'd5, 32'd0);
    set_way(1, 1, EXC_NONE, 0, 3'd0, 0, 32'd1, 32'd2, 32'd0);
    step();
    check("teq_code", 32'(out_exc_code), 32'h0D);
    check("teq_way",  32'(out_way),      32'h1);
    check("teq_hit",  32'(out_trap_hit), 32'd1);
    check("teq_cnt",  32'(trap_count),   32'd1);
    check("model_teq_cnt", 32'(m_cnt16), 32'd1);

    // way0 TNE 7!=7 not taken must not mask way1's upstream exception.
    set_way(0, 1, EXC_NONE, 1, 3'd1, 0, 32'd7, 32'd7, 32'd0);
    set_way(1, 1, 5'h04,    0, 3'd0, 0, 32'd0, 32'd0, 32'd0);
    step();
    check("tne_code", 32'(out_exc_code), 32'h04);
    check("tne_way",  32'(out_way),      32'h2);
    check("tne_hit",  32'(out_trap_hit), 32'd0);
    check("tne_cnt",  32'(trap_count),   32'd1);
    check("model_tne_code", 32'(m_code), 32'h04);

    // Signed vs unsigned boundary against the immediate.
    set_way(1, 0, EXC_NONE, 0, 3'd0, 0, 32'd0, 32'd0, 32'd0);
    set_way(0, 1, EXC_NONE, 1, 3'd4, 1, 32'h8000_0000, 32'd0, 32'd1);
    step();
    check("lt_code", 32'(out_exc_code), 32'h0D);
    check("lt_cnt",  32'(trap_count),   32'd2);
    set_way(0, 1, EXC_NONE, 1, 3'd5, 1, 32'h8000_0000, 32'd0, 32'd1);
    step();
    check("ltu_code",  32'(out_exc_code), 32'h00);
    check("ltu_valid", 32'(out_valid),    32'd1);
    check("ltu_way",   32'(out_way),      32'h0);

    // Upstream EXC_TR wins but is not a taken trap and does not count.
    set_way(0, 1, EXC_TR, 1, 3'd0, 0, 32'd3, 32'd3, 32'd0);
    step();
    check("up_tr_code", 32'(out_exc_code), 32'h0D);
    check("up_tr_hit",  32'(out_trap_hit), 32'd0);
    check("up_tr_cnt",  32'(trap_count),   32'd2);

    // Capture a trap, then stall 3 cycles with changing inputs.
    set_way(0, 1, EXC_NONE, 1, 3'd2, 0, 32'd9, 32'd9, 32'd0);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_ways();
      step();
      check("stall_code", 32'(out_exc_code), 32'h0D);
      check("stall_cnt",  32'(trap_count),   32'd3);
    end
    flush = 1;
    step();
    check("stall_flush_valid", 32'(out_valid),    32'd0);
    check("stall_flush_cnt",   32'(trap_count),   32'd3);
    flush = 0;

    // Reset during a stall that holds a valid trap.
    stall = 0;
    set_way(0, 1, EXC_NONE, 1, 3'd0, 0, 32'd1, 32'd1, 32'd0);
    set_way(1, 0, EXC_NONE, 0, 3'd0, 0, 32'd0, 32'd0, 32'd0);
    step();
    stall = 1; step();
    check("pre_rst_hit", 32'(out_trap_hit), 32'd1);
    rst = 1; step();
    check("rst_stall_valid", 32'(out_valid),    32'd0);
    check("rst_stall_code",  32'(out_exc_code), 32'd0);
    check("rst_stall_way",   32'(out_way),      32'd0);
    check("rst_stall_cnt",   32'(trap_count),   32'd0);
    rst = 0; stall = 0;

    // 17 consecutive taken traps saturate the 4-bit counter at 15.
    for (int i = 0; i < 17; i++) begin
      set_way(0, 1, EXC_NONE, 1, 3'd3, 1, 32'($urandom_range(100, 1000)), 32'd0, 32'd50);
      step();
    end
    check("sat_cnt4",  32'(s_trap_count), 32'd15);
    check("sat_cnt16", 32'(trap_count),   32'd17);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      randomize_ways();
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 5);
      rst   = ($urandom_range(0, 999) < 5);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
